// File: rtl/id_ex_stage_if.sv
// Bundles the ID-side inputs, register-file read port, writeback bypass and ID/EX outputs of id_ex_stage.
// The master side drives the instruction, register-file data and writeback; the slave side is the stage itself.
interface id_ex_stage_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [4:0]  rf_read_reg_1;
    logic [4:0]  rf_read_reg_2;
    logic [31:0] rf_read_data_1;
    logic [31:0] rf_read_data_2;
    logic        wb_regWrite;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_flush;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc4;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic        ex_regWrite;
    logic        ex_memRead;
    logic        ex_memWrite;
    logic        ex_branch;
    logic        ex_aluSrc;
    logic [3:0]  ex_aluOp;

    modport master (
        output id_valid, id_instr, id_pc4, rf_read_data_1, rf_read_data_2,
               wb_regWrite, wb_write_reg, wb_write_data, ex_flush,
        input  rf_read_reg_1, rf_read_reg_2, stall, ex_valid, ex_pc4, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest, ex_regWrite, ex_memRead,
               ex_memWrite, ex_branch, ex_aluSrc, ex_aluOp
    );

    modport slave (
        input  id_valid, id_instr, id_pc4, rf_read_data_1, rf_read_data_2,
               wb_regWrite, wb_write_reg, wb_write_data, ex_flush,
        output rf_read_reg_1, rf_read_reg_2, stall, ex_valid, ex_pc4, ex_rs_data,
               ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dest, ex_regWrite, ex_memRead,
               ex_memWrite, ex_branch, ex_aluSrc, ex_aluOp
    );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS decode/issue stage: decodes control, bypasses same-cycle writeback into the operands,
// detects load-use hazards and owns the ID/EX pipeline register.
module id_ex_stage (
    input logic           clk,
    input logic           rst,
    id_ex_stage_if.slave  bus
);
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd;
    logic        legal, uses_rt;
    logic [4:0]  dest;
    logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_alu_src;
    logic [3:0]  dec_alu_op;
    logic [31:0] rs_val, rt_val;
    logic        hz;

    logic        ex_valid_d, ex_valid_q;
    logic [31:0] ex_pc4_d, ex_pc4_q;
    logic [31:0] ex_rs_data_d, ex_rs_data_q;
    logic [31:0] ex_rt_data_d, ex_rt_data_q;
    logic [31:0] ex_imm_d, ex_imm_q;
    logic [4:0]  ex_rs_d, ex_rs_q;
    logic [4:0]  ex_rt_d, ex_rt_q;
    logic [4:0]  ex_dest_d, ex_dest_q;
    logic        ex_reg_write_d, ex_reg_write_q;
    logic        ex_mem_read_d, ex_mem_read_q;
    logic        ex_mem_write_d, ex_mem_write_q;
    logic        ex_branch_d, ex_branch_q;
    logic        ex_alu_src_d, ex_alu_src_q;
    logic [3:0]  ex_alu_op_d, ex_alu_op_q;

    assign opcode = bus.id_instr[31:26];
    assign rs     = bus.id_instr[25:21];
    assign rt     = bus.id_instr[20:16];
    assign rd     = bus.id_instr[15:11];
    assign funct  = bus.id_instr[5:0];

    assign bus.rf_read_reg_1 = rs;
    assign bus.rf_read_reg_2 = rt;

    always_comb begin
        legal         = 1'b0;
        uses_rt       = 1'b0;
        dest          = rt;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_alu_src   = 1'b0;
        dec_alu_op    = 4'b0000;
        case (opcode)
            OP_RTYPE: begin
                legal         = 1'b1;
                uses_rt       = 1'b1;
                dest          = rd;
                dec_reg_write = 1'b1;
                case (funct)
                    6'h20:   dec_alu_op = 4'b0010;
                    6'h22:   dec_alu_op = 4'b0110;
                    6'h24:   dec_alu_op = 4'b0000;
                    6'h25:   dec_alu_op = 4'b0001;
                    6'h2A:   dec_alu_op = 4'b0111;
                    default: legal      = 1'b0;
                endcase
            end
            OP_ADDI: begin
                legal         = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = 4'b0010;
            end
            OP_LW: begin
                legal         = 1'b1;
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = 4'b0010;
            end
            OP_SW: begin
                legal         = 1'b1;
                uses_rt       = 1'b1;
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_alu_op    = 4'b0010;
            end
            OP_BEQ: begin
                legal         = 1'b1;
                uses_rt       = 1'b1;
                dec_branch    = 1'b1;
                dec_alu_op    = 4'b0110;
            end
            default: legal = 1'b0;
        endcase
        if (dest == 5'd0) dec_reg_write = 1'b0;
    end

    // Register 0 reads as zero even if writeback targets it or the file returns junk.
    always_comb begin
        if (rs == 5'd0)
            rs_val = '0;
        else if (bus.wb_regWrite && bus.wb_write_reg == rs)
            rs_val = bus.wb_write_data;
        else
            rs_val = bus.rf_read_data_1;

        if (rt == 5'd0)
            rt_val = '0;
        else if (bus.wb_regWrite && bus.wb_write_reg == rt)
            rt_val = bus.wb_write_data;
        else
            rt_val = bus.rf_read_data_2;
    end

    assign hz = bus.id_valid & ex_valid_q & ex_mem_read_q & (ex_dest_q != 5'd0) &
                ((ex_dest_q == rs) | (uses_rt & (ex_dest_q == rt)));
    assign bus.stall = hz & ~bus.ex_flush;

    always_comb begin
        ex_valid_d     = 1'b0;
        ex_pc4_d       = '0;
        ex_rs_data_d   = '0;
        ex_rt_data_d   = '0;
        ex_imm_d       = '0;
        ex_rs_d        = '0;
        ex_rt_d        = '0;
        ex_dest_d      = '0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        ex_mem_write_d = 1'b0;
        ex_branch_d    = 1'b0;
        ex_alu_src_d   = 1'b0;
        ex_alu_op_d    = '0;
        if (!(bus.ex_flush || hz)) begin
            ex_valid_d     = bus.id_valid & legal;
            ex_pc4_d       = bus.id_pc4;
            ex_rs_data_d   = rs_val;
            ex_rt_data_d   = rt_val;
            ex_imm_d       = {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
            ex_rs_d        = rs;
            ex_rt_d        = rt;
            ex_dest_d      = dest;
            ex_reg_write_d = ex_valid_d & dec_reg_write;
            ex_mem_read_d  = ex_valid_d & dec_mem_read;
            ex_mem_write_d = ex_valid_d & dec_mem_write;
            ex_branch_d    = ex_valid_d & dec_branch;
            ex_alu_src_d   = ex_valid_d & dec_alu_src;
            ex_alu_op_d    = ex_valid_d ? dec_alu_op : 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_pc4_q       <= '0;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_imm_q       <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dest_q      <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_branch_q    <= 1'b0;
            ex_alu_src_q   <= 1'b0;
            ex_alu_op_q    <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc4_q       <= ex_pc4_d;
            ex_rs_data_q   <= ex_rs_data_d;
            ex_rt_data_q   <= ex_rt_data_d;
            ex_imm_q       <= ex_imm_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dest_q      <= ex_dest_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_branch_q    <= ex_branch_d;
            ex_alu_src_q   <= ex_alu_src_d;
            ex_alu_op_q    <= ex_alu_op_d;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc4      = ex_pc4_q;
    assign bus.ex_rs_data  = ex_rs_data_q;
    assign bus.ex_rt_data  = ex_rt_data_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rs       = ex_rs_q;
    assign bus.ex_rt       = ex_rt_q;
    assign bus.ex_dest     = ex_dest_q;
    assign bus.ex_regWrite = ex_reg_write_q;
    assign bus.ex_memRead  = ex_mem_read_q;
    assign bus.ex_memWrite = ex_mem_write_q;
    assign bus.ex_branch   = ex_branch_q;
    assign bus.ex_aluSrc   = ex_alu_src_q;
    assign bus.ex_aluOp    = ex_alu_op_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Vector-table bench for id_ex_stage: each record drives one ID cycle; expected ID/EX contents are
// queued when driven and compared one edge later, combinational stall/address outputs are checked in-cycle.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if bus();
    id_ex_stage u_dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        valid;
        logic [31:0] pc4, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, dest;
        logic        rw, mr, mw, br, as;
        logic [3:0]  op;
    } ex_t;

    typedef struct {
        logic        r, vld;
        logic [31:0] instr, pc4, rd1, rd2;
        logic        wbwe;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic        fl, st, chkd;
        ex_t         e;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] rtyp(input logic [4:0] s, t, d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'h00, fn};
    endfunction

    function automatic logic [31:0] ityp(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic ex_t bub();
        ex_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic ex_t iss(input logic val, input logic [31:0] rsd, rtd, im,
                                input logic [4:0] s, t, d,
                                input logic rw, mr, mw, br, as, input logic [3:0] op);
        ex_t e;
        e = '{valid: val, pc4: 32'h0, rs_data: rsd, rt_data: rtd, imm: im, rs: s, rt: t,
              dest: d, rw: rw, mr: mr, mw: mw, br: br, as: as, op: op};
        return e;
    endfunction

    task automatic v(input logic r, vld, input logic [31:0] instr, rd1, rd2,
                     input logic wbwe, input logic [4:0] wbreg, input logic [31:0] wbdata,
                     input logic fl, st, chkd, input ex_t e);
        vec_t x;
        x.r = r; x.vld = vld; x.instr = instr; x.rd1 = rd1; x.rd2 = rd2;
        x.wbwe = wbwe; x.wbreg = wbreg; x.wbdata = wbdata; x.fl = fl; x.st = st; x.chkd = chkd;
        x.pc4 = 32'h100 + 32'(vecs.size() * 4);
        x.e = e;
        x.e.pc4 = (!r && !fl && !st) ? x.pc4 : 32'h0;
        vecs.push_back(x);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst                = x.r;
        bus.id_valid       = x.vld;
        bus.id_instr       = x.instr;
        bus.id_pc4         = x.pc4;
        bus.rf_read_data_1 = x.rd1;
        bus.rf_read_data_2 = x.rd2;
        bus.wb_regWrite    = x.wbwe;
        bus.wb_write_reg   = x.wbreg;
        bus.wb_write_data  = x.wbdata;
        bus.ex_flush       = x.fl;
    endtask

    logic [31:0] add3, add4, sub4, lw2, add5, addi2, addi0, addi7, beq12, sw2, ill_op, ill_fn;

    initial begin
        vec_t x, p;
        logic [31:0] ins;
        add3   = rtyp(5'd1, 5'd2, 5'd3, 6'h20);
        add4   = rtyp(5'd1, 5'd0, 5'd4, 6'h20);
        sub4   = rtyp(5'd0, 5'd2, 5'd4, 6'h22);
        lw2    = ityp(6'h23, 5'd1, 5'd2, 16'h0004);
        add5   = rtyp(5'd2, 5'd3, 5'd5, 6'h20);
        addi2  = ityp(6'h08, 5'd7, 5'd2, 16'h0001);
        addi0  = ityp(6'h08, 5'd1, 5'd0, 16'h0009);
        addi7  = ityp(6'h08, 5'd1, 5'd7, 16'h8000);
        beq12  = ityp(6'h04, 5'd1, 5'd2, 16'h0010);
        sw2    = ityp(6'h2B, 5'd1, 5'd2, 16'h0008);
        ill_op = ityp(6'h3F, 5'd1, 5'd2, 16'h0010);
        ill_fn = rtyp(5'd1, 5'd2, 5'd3, 6'h21);

        //  rst vld instr  rd1        rd2       wbwe wbreg wbdata        fl st chkd expected
        v(1, 1, add3,  32'd5,     32'd7,    0, 5'd0, 32'h0,      0, 0, 1, bub());
        v(0, 1, add3,  32'd5,     32'd7,    0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'd5, 32'd7, 32'h1820, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0, 4'b0010));
        v(0, 1, add4,  32'd0,     32'h55,   1, 5'd1, 32'hDEAD,   0, 0, 1, iss(1, 32'hDEAD, 32'd0, 32'h2020, 5'd1, 5'd0, 5'd4, 1, 0, 0, 0, 0, 4'b0010));
        v(0, 1, add4,  32'h11,    32'h55,   1, 5'd0, 32'hDEAD,   0, 0, 1, iss(1, 32'h11, 32'd0, 32'h2020, 5'd1, 5'd0, 5'd4, 1, 0, 0, 0, 0, 4'b0010));
        v(0, 1, sub4,  32'h99,    32'd3,    1, 5'd0, 32'hBEEF,   0, 0, 1, iss(1, 32'd0, 32'd3, 32'h2022, 5'd0, 5'd2, 5'd4, 1, 0, 0, 0, 0, 4'b0110));
        v(0, 1, lw2,   32'h1000,  32'h77,   0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'h1000, 32'h77, 32'h4, 5'd1, 5'd2, 5'd2, 1, 1, 0, 0, 1, 4'b0010));
        v(0, 1, add5,  32'hA,     32'hB,    0, 5'd0, 32'h0,      0, 1, 1, bub());
        v(0, 1, add5,  32'hA,     32'hB,    0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'hA, 32'hB, 32'h2820, 5'd2, 5'd3, 5'd5, 1, 0, 0, 0, 0, 4'b0010));
        v(0, 1, lw2,   32'h1000,  32'h77,   0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'h1000, 32'h77, 32'h4, 5'd1, 5'd2, 5'd2, 1, 1, 0, 0, 1, 4'b0010));
        v(0, 1, addi2, 32'h20,    32'h30,   0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'h20, 32'h30, 32'h1, 5'd7, 5'd2, 5'd2, 1, 0, 0, 0, 1, 4'b0010));
        v(0, 1, lw2,   32'h1000,  32'h77,   0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'h1000, 32'h77, 32'h4, 5'd1, 5'd2, 5'd2, 1, 1, 0, 0, 1, 4'b0010));
        v(0, 1, add5,  32'hA,     32'hB,    0, 5'd0, 32'h0,      1, 0, 1, bub());
        v(0, 1, add5,  32'hA,     32'hB,    0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'hA, 32'hB, 32'h2820, 5'd2, 5'd3, 5'd5, 1, 0, 0, 0, 0, 4'b0010));
        v(0, 1, add3,  32'd5,     32'd7,    0, 5'd0, 32'h0,      1, 0, 1, bub());
        v(0, 1, ill_op,32'd1,     32'd2,    0, 5'd0, 32'h0,      0, 0, 0, bub());
        v(0, 1, addi0, 32'd4,     32'h66,   0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'd4, 32'd0, 32'h9, 5'd1, 5'd0, 5'd0, 0, 0, 0, 0, 1, 4'b0010));
        v(0, 1, addi7, 32'd1,     32'd2,    0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'd1, 32'd2, 32'hFFFF8000, 5'd1, 5'd7, 5'd7, 1, 0, 0, 0, 1, 4'b0010));
        v(0, 1, ill_fn,32'd1,     32'd2,    0, 5'd0, 32'h0,      0, 0, 0, bub());
        v(0, 1, beq12, 32'd1,     32'd2,    0, 5'd0, 32'h0,      0, 0, 0, iss(1, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 4'b0110));
        v(0, 1, lw2,   32'h1000,  32'h77,   0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'h1000, 32'h77, 32'h4, 5'd1, 5'd2, 5'd2, 1, 1, 0, 0, 1, 4'b0010));
        v(0, 1, sw2,   32'd1,     32'd2,    0, 5'd0, 32'h0,      0, 1, 1, bub());
        v(0, 1, sw2,   32'd1,     32'd2,    0, 5'd0, 32'h0,      0, 0, 0, iss(1, 32'd0, 32'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, 4'b0010));
        v(0, 0, add3,  32'd5,     32'd7,    0, 5'd0, 32'h0,      0, 0, 0, bub());
        v(0, 1, lw2,   32'h1000,  32'h77,   0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'h1000, 32'h77, 32'h4, 5'd1, 5'd2, 5'd2, 1, 1, 0, 0, 1, 4'b0010));
        v(1, 1, add5,  32'hA,     32'hB,    0, 5'd0, 32'h0,      0, 1, 1, bub());
        v(0, 1, add5,  32'hA,     32'hB,    0, 5'd0, 32'h0,      0, 0, 1, iss(1, 32'hA, 32'hB, 32'h2820, 5'd2, 5'd3, 5'd5, 1, 0, 0, 0, 0, 4'b0010));

        // First reset edge so the state is defined before the table starts checking stall.
        drive(vecs[0]);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            x = vecs[i];
            @(negedge clk);
            drive(x);
            #1;
            ins = x.instr;
            chk($sformatf("v%0d.stall", i), {31'd0, bus.stall}, {31'd0, x.st});
            chk($sformatf("v%0d.rf_read_reg_1", i), {27'd0, bus.rf_read_reg_1}, {27'd0, ins[25:21]});
            chk($sformatf("v%0d.rf_read_reg_2", i), {27'd0, bus.rf_read_reg_2}, {27'd0, ins[20:16]});
            sb.push_back(x);
            @(posedge clk);
            #1;
            p = sb.pop_front();
            chk($sformatf("v%0d.ex_valid", i),    {31'd0, bus.ex_valid},    {31'd0, p.e.valid});
            chk($sformatf("v%0d.ex_regWrite", i), {31'd0, bus.ex_regWrite}, {31'd0, p.e.rw});
            chk($sformatf("v%0d.ex_memRead", i),  {31'd0, bus.ex_memRead},  {31'd0, p.e.mr});
            chk($sformatf("v%0d.ex_memWrite", i), {31'd0, bus.ex_memWrite}, {31'd0, p.e.mw});
            chk($sformatf("v%0d.ex_branch", i),   {31'd0, bus.ex_branch},   {31'd0, p.e.br});
            chk($sformatf("v%0d.ex_aluSrc", i),   {31'd0, bus.ex_aluSrc},   {31'd0, p.e.as});
            chk($sformatf("v%0d.ex_aluOp", i),    {28'd0, bus.ex_aluOp},    {28'd0, p.e.op});
            if (p.chkd) begin
                chk($sformatf("v%0d.ex_pc4", i),     bus.ex_pc4,     p.e.pc4);
                chk($sformatf("v%0d.ex_rs_data", i), bus.ex_rs_data, p.e.rs_data);
                chk($sformatf("v%0d.ex_rt_data", i), bus.ex_rt_data, p.e.rt_data);
                chk($sformatf("v%0d.ex_imm", i),     bus.ex_imm,     p.e.imm);
                chk($sformatf("v%0d.ex_rs", i),      {27'd0, bus.ex_rs},   {27'd0, p.e.rs});
                chk($sformatf("v%0d.ex_rt", i),      {27'd0, bus.ex_rt},   {27'd0, p.e.rt});
                chk($sformatf("v%0d.ex_dest", i),    {27'd0, bus.ex_dest}, {27'd0, p.e.dest});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
